uart_tx_frame: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 transmit-only block. It adds:
- a built-in baud divider;
- configurable data width, parity mode and stop-bit count;
- a valid/ready input handshake that supports gap-free back-to-back frames;
- a frame-done pulse.

It sits between an on-chip producer (result serializer, debug streamer) and the board-level TX pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_baud_gen.sv | 17 +
 rtl/uart_tx_frame.sv | 96 +++++++++
 tb/tb_uart_tx_frame.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity mode constants and FSM state encoding shared by the UART transmitter and receiver.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter whose tick marks the last cycle of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input, parity, 1-2 stop bits
// and a one-cycle done pulse; frames chain gap-free when a word is offered at the last stop edge.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $fatal(1, "uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $fatal(1, "uart_tx_frame: CLKS_PER_BIT must be at least 2");
  end
  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IW-1:0]        idx_q;
  logic                 stop_q, par_q, tx_q, done_q, tick, last_stop, hs;
  assign last_stop = state_q == ST_STOP && tick && stop_q == 1'(STOP_BITS - 1);
  assign in_ready  = !rst && (state_q == ST_IDLE || last_stop);
  assign hs        = in_valid && in_ready;
  assign tx        = tx_q;
  assign done      = done_q;
  assign busy      = state_q != ST_IDLE;
  // Held in restart while idle so the first bit period always starts from zero.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .restart(hs || state_q == ST_IDLE),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_stop;
      if (hs) begin
        state_q <= ST_START;
        tx_q    <= 1'b0;
        shift_q <= in_data;
        par_q   <= ^in_data ^ (PARITY == PARITY_ODD);
      end else if (tick) begin
        case (state_q)
          ST_START: begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= '0;
          end
          ST_DATA:
            if (idx_q == IW'(DATA_BITS - 1)) begin
              state_q <= PARITY != PARITY_NONE ? ST_PARITY : ST_STOP;
              tx_q    <= PARITY != PARITY_NONE ? par_q : 1'b1;
              stop_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
          ST_STOP:
            if (last_stop) state_q <= ST_IDLE;
            else           stop_q  <= 1'b1;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for three uart_tx_frame configurations (8N1, 8E1, 5O2).
module tb_uart_tx_frame;
  localparam int CPB [3] = '{4, 4, 3};
  localparam int DBS [3] = '{8, 8, 5};
  localparam int PMS [3] = '{0, 2, 1};
  localparam int SBS [3] = '{1, 1, 2};
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] v = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [4:0] d2 = '0;
  logic [2:0] rdy, tx, bsy, dn;
  logic       exp_q [$];
  logic       e;
  int         cur = 0;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  always #5 clk = ~clk;
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(d0), .in_ready(rdy[0]),
    .tx(tx[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(d1), .in_ready(rdy[1]),
    .tx(tx[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(3), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_data(d2), .in_ready(rdy[2]),
    .tx(tx[2]), .busy(bsy[2]), .done(dn[2]));
  function automatic int flen(input int k);
    return 1 + DBS[k] + (PMS[k] != 0 ? 1 : 0) + SBS[k];
  endfunction
  // Expected line level for every clock cycle of one frame.
  task automatic push_frame(input int k, input logic [8:0] w);
    logic bits [$];
    int   ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DBS[k]; i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (PMS[k] != 0) bits.push_back(((ones % 2) == 1) ^ (PMS[k] == 1));
    for (int i = 0; i < SBS[k]; i++) bits.push_back(1'b1);
    foreach (bits[i]) repeat (CPB[k]) exp_q.push_back(bits[i]);
  endtask
  task automatic set_in(input int k, input logic val, input logic [8:0] w);
    v[k] = val;
    if (k == 0) d0 = w[7:0];
    else if (k == 1) d1 = w[7:0];
    else d2 = w[4:0];
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (tx[cur] !== e) begin
        errors++;
        $display("FAIL tx_bit dut=%0d t=%0t got %b want %b", cur, $time, tx[cur], e);
      end
    end else if (!rst) begin
      checks++;
      if (tx[cur] !== 1'b1) begin
        errors++;
        $display("FAIL tx_idle dut=%0d t=%0t got %b want 1", cur, $time, tx[cur]);
      end
    end
    if (dn[cur] === 1'b1) done_cnt++;
  end
  task automatic send_frame(input int k, input logic [8:0] w);
    int fc, lowc, dc;
    fc = flen(k) * CPB[k];
    lowc = 0;
    cur = k;
    @(negedge clk);
    set_in(k, 1'b1, w);
    checks++;
    if (rdy[k] !== 1'b1) begin errors++; $display("FAIL ready_idle dut=%0d got %b want 1", k, rdy[k]); end
    @(posedge clk);
    push_frame(k, w);
    dc = done_cnt;
    for (int i = 1; i <= fc; i++) begin
      @(negedge clk);
      if (i == 1) set_in(k, 1'b0, 9'h0);
      if (i < fc) lowc += (rdy[k] === 1'b0) ? 1 : 0;
      else begin
        checks++;
        if (rdy[k] !== 1'b1) begin errors++; $display("FAIL ready_last dut=%0d got %b want 1", k, rdy[k]); end
      end
    end
    checks++;
    if (lowc != fc - 1) begin errors++; $display("FAIL ready_low_cycles dut=%0d got %0d want %0d", k, lowc, fc - 1); end
    @(negedge clk);
    checks++;
    if (dn[k] !== 1'b1 || bsy[k] !== 1'b0) begin
      errors++; $display("FAIL done_pulse dut=%0d got done=%b busy=%b want done=1 busy=0", k, dn[k], bsy[k]);
    end
    @(negedge clk);
    checks++;
    if (dn[k] !== 1'b0 || done_cnt != dc + 1) begin
      errors++; $display("FAIL done_once dut=%0d got done=%b count=%0d want done=0 count=1", k, dn[k], done_cnt - dc);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000 || rdy !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got tx=%b busy=%b done=%b ready=%b want 111/000/000/000", tx, bsy, dn, rdy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy !== 3'b111) begin errors++; $display("FAIL ready_after_reset got %b want 111", rdy); end
  endtask
  task automatic test_8n1;
    send_frame(0, 9'h0A5);
  endtask
  task automatic test_even_parity;
    send_frame(1, 9'h007);
    send_frame(1, 9'h003);
  endtask
  task automatic test_odd_5bit_2stop;
    send_frame(2, 9'h01F);
  endtask
  task automatic test_back_to_back;
    int fc, dc;
    fc = flen(0) * CPB[0];
    cur = 0;
    @(negedge clk);
    set_in(0, 1'b1, 9'h055);
    @(posedge clk);
    push_frame(0, 9'h055);
    dc = done_cnt;
    for (int i = 1; i <= fc; i++) begin
      @(negedge clk);
      if (i == 1) d0 = 8'hAA;
      if (i == fc) begin
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", rdy[0]); end
      end
    end
    @(posedge clk);
    push_frame(0, 9'h0AA);
    @(negedge clk);
    set_in(0, 1'b0, 9'h0);
    checks++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done got done=%b busy=%b want 1/1", dn[0], bsy[0]);
    end
    repeat (fc) @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_second_done got done=%b busy=%b want 1/0", dn[0], bsy[0]);
    end
    @(negedge clk);
    checks++;
    if (done_cnt != dc + 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - dc); end
  endtask
  task automatic test_change_while_busy;
    int fc, dc;
    fc = flen(1) * CPB[1];
    cur = 1;
    @(negedge clk);
    set_in(1, 1'b1, 9'h003);
    @(posedge clk);
    push_frame(1, 9'h003);
    dc = done_cnt;
    for (int i = 1; i <= fc; i++) begin
      @(negedge clk);
      if (i == 10) begin
        d1 = 8'hF0;
        checks++;
        if (rdy[1] !== 1'b0 || bsy[1] !== 1'b1) begin
          errors++; $display("FAIL busy_hold got ready=%b busy=%b want 0/1", rdy[1], bsy[1]);
        end
      end
    end
    @(posedge clk);
    push_frame(1, 9'h0F0);
    @(negedge clk);
    set_in(1, 1'b0, 9'h0);
    repeat (fc) @(negedge clk);
    checks++;
    if (dn[1] !== 1'b1) begin errors++; $display("FAIL change_second_done got %b want 1", dn[1]); end
    @(negedge clk);
    checks++;
    if (done_cnt != dc + 2) begin errors++; $display("FAIL change_done_count got %0d want 2", done_cnt - dc); end
  endtask
  task automatic test_reset_mid_frame;
    int dc;
    cur = 0;
    @(negedge clk);
    set_in(0, 1'b1, 9'h042);
    @(posedge clk);
    push_frame(0, 9'h042);
    dc = done_cnt;
    @(negedge clk);
    set_in(0, 1'b0, 9'h0);
    repeat (17) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (tx[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      errors++; $display("FAIL async_reset got tx=%b busy=%b ready=%b done=%b want 1/0/0/0", tx[0], bsy[0], rdy[0], dn[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL ready_after_abort got %b want 1", rdy[0]); end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != dc) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt - dc); end
    send_frame(0, 9'h096);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_8n1;
    test_even_parity;
    test_odd_5bit_2stop;
    test_back_to_back;
    test_change_while_busy;
    test_reset_mid_frame;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
